// File: rtl/motor_pwm_ramp_ctrl.sv
// Soft-start/soft-stop sequencer for the elevator motor PWM timer: latches the period,
// then slews the compare value toward a target at a programmable rate, with emergency stop.
module motor_pwm_ramp_ctrl #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             cmd_run,
    input  logic             estop,
    input  logic [CNT_W-1:0] target_duty,
    input  logic [CNT_W-1:0] step_size,
    input  logic [CNT_W-1:0] step_interval,
    input  logic [CNT_W-1:0] period_cfg,
    input  logic [31:0]      pres_cfg,
    output logic [1:0]       control,
    output logic [31:0]      prescalor,
    output logic [31:0]      max_count,
    output logic [31:0]      compare,
    output logic [1:0]       state,
    output logic             busy,
    output logic             at_target
);

    localparam int DW = CNT_W + 1;

    typedef enum logic [1:0] {
        ST_OFF  = 2'b00,
        ST_UP   = 2'b01,
        ST_HOLD = 2'b10,
        ST_DOWN = 2'b11
    } state_t;

    state_t           state_q, state_d;
    logic [DW-1:0]    duty_q, duty_d;
    logic [CNT_W-1:0] tmr_q, tmr_d;
    logic [CNT_W-1:0] period_q, period_d;
    logic [31:0]      pres_q, pres_d;
    logic [1:0]       ctrl_q, ctrl_d;
    logic             busy_q, busy_d;
    logic             hold_q, hold_d;

    logic [CNT_W-1:0] per_eff;
    logic [DW-1:0]    lim, tgt, stp;
    logic             tick;

    function automatic logic [DW-1:0] sat_up(input logic [DW-1:0] d,
                                             input logic [DW-1:0] s,
                                             input logic [DW-1:0] t);
        logic [DW:0] sum;
        sum = {1'b0, d} + {1'b0, s};
        if (sum >= {1'b0, t}) return t;
        return sum[DW-1:0];
    endfunction

    // Caller guarantees d >= t, so d - t cannot wrap.
    function automatic logic [DW-1:0] sat_down(input logic [DW-1:0] d,
                                               input logic [DW-1:0] s,
                                               input logic [DW-1:0] t);
        if ((d - t) <= s) return t;
        return d - s;
    endfunction

    always_comb begin
        // In OFF the period about to be latched is the one that bounds the target.
        per_eff = (state_q == ST_OFF) ? period_cfg : period_q;
        lim     = {1'b0, per_eff} + DW'(1);
        if (!cmd_run)
            tgt = '0;
        else if ({1'b0, target_duty} < lim)
            tgt = {1'b0, target_duty};
        else
            tgt = lim;
        stp  = (step_size == '0) ? DW'(1) : {1'b0, step_size};
        tick = (tmr_q == step_interval);
    end

    always_comb begin
        state_d  = state_q;
        duty_d   = duty_q;
        tmr_d    = tmr_q;
        period_d = period_q;
        pres_d   = pres_q;
        if (estop) begin
            state_d = ST_OFF;
            duty_d  = '0;
            tmr_d   = '0;
        end else begin
            unique case (state_q)
                ST_OFF: begin
                    if (cmd_run) begin
                        period_d = period_cfg;
                        pres_d   = pres_cfg;
                        duty_d   = '0;
                        tmr_d    = '0;
                        state_d  = (tgt == '0) ? ST_HOLD : ST_UP;
                    end
                end
                ST_UP: begin
                    if (tgt < duty_q) begin
                        state_d = ST_DOWN;
                        tmr_d   = '0;
                    end else if (duty_q == tgt) begin
                        state_d = ST_HOLD;
                    end else if (tick) begin
                        duty_d = sat_up(duty_q, stp, tgt);
                        tmr_d  = '0;
                    end else begin
                        tmr_d = tmr_q + CNT_W'(1);
                    end
                end
                ST_HOLD: begin
                    if (tgt > duty_q) begin
                        state_d = ST_UP;
                        tmr_d   = '0;
                    end else if (tgt < duty_q) begin
                        state_d = ST_DOWN;
                        tmr_d   = '0;
                    end else if (!cmd_run && duty_q == '0) begin
                        state_d = ST_OFF;
                    end
                end
                ST_DOWN: begin
                    if (tgt > duty_q) begin
                        state_d = ST_UP;
                        tmr_d   = '0;
                    end else if (duty_q == tgt) begin
                        state_d = cmd_run ? ST_HOLD : ST_OFF;
                    end else if (tick) begin
                        duty_d = sat_down(duty_q, stp, tgt);
                        tmr_d  = '0;
                    end else begin
                        tmr_d = tmr_q + CNT_W'(1);
                    end
                end
                default: state_d = ST_OFF;
            endcase
        end
        // Timer mode only depends on OFF vs. running, so it never toggles mid-run.
        ctrl_d = (state_d == ST_OFF) ? 2'b00 : 2'b10;
        busy_d = (state_d != ST_OFF);
        hold_d = (state_d == ST_HOLD);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q  <= ST_OFF;
            duty_q   <= '0;
            tmr_q    <= '0;
            period_q <= '0;
            pres_q   <= '0;
            ctrl_q   <= 2'b00;
            busy_q   <= 1'b0;
            hold_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            duty_q   <= duty_d;
            tmr_q    <= tmr_d;
            period_q <= period_d;
            pres_q   <= pres_d;
            ctrl_q   <= ctrl_d;
            busy_q   <= busy_d;
            hold_q   <= hold_d;
        end
    end

    assign control   = ctrl_q;
    assign prescalor = pres_q;
    assign max_count = {{(32-CNT_W){1'b0}}, period_q};
    assign compare   = {{(32-DW){1'b0}}, duty_q};
    assign state     = state_q;
    assign busy      = busy_q;
    assign at_target = hold_q;

endmodule

// File: tb/tb_motor_pwm_ramp_ctrl.sv
// Directed bench for motor_pwm_ramp_ctrl: inputs driven and outputs sampled on the falling edge.
module tb_motor_pwm_ramp_ctrl;

    logic        clk = 1'b0;
    logic        reset;
    logic        cmd_run;
    logic        estop;
    logic [15:0] target_duty;
    logic [15:0] step_size;
    logic [15:0] step_interval;
    logic [15:0] period_cfg;
    logic [31:0] pres_cfg;
    logic [1:0]  control;
    logic [31:0] prescalor;
    logic [31:0] max_count;
    logic [31:0] compare;
    logic [1:0]  state;
    logic        busy;
    logic        at_target;

    int n_checks = 0;
    int n_errors = 0;

    localparam logic [1:0] S_OFF = 2'b00, S_UP = 2'b01, S_HOLD = 2'b10, S_DOWN = 2'b11;

    always #5 clk = ~clk;

    motor_pwm_ramp_ctrl #(.CNT_W(16)) dut (
        .clk          (clk),
        .reset        (reset),
        .cmd_run      (cmd_run),
        .estop        (estop),
        .target_duty  (target_duty),
        .step_size    (step_size),
        .step_interval(step_interval),
        .period_cfg   (period_cfg),
        .pres_cfg     (pres_cfg),
        .control      (control),
        .prescalor    (prescalor),
        .max_count    (max_count),
        .compare      (compare),
        .state        (state),
        .busy         (busy),
        .at_target    (at_target)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic edges(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic check_idle(input string tag);
        check({tag, "_state"},  32'(state), 32'(S_OFF));
        check({tag, "_ctrl"},   32'(control), 32'd0);
        check({tag, "_cmp"},    compare, 32'd0);
        check({tag, "_busy"},   32'(busy), 32'd0);
        check({tag, "_attgt"},  32'(at_target), 32'd0);
    endtask

    initial begin
        reset = 1'b0; cmd_run = 1'b0; estop = 1'b0;
        target_duty = 16'd50; step_size = 16'd10; step_interval = 16'd3;
        period_cfg = 16'd99; pres_cfg = 32'd3;
        edges(2);
        check_idle("rst");
        check("rst_max",  max_count, 32'd0);
        check("rst_pres", prescalor, 32'd0);

        // Ramp up 0..50 in steps of 10, one step every 4 edges.
        cmd_run = 1'b1;
        reset   = 1'b1;
        edges(1);
        check("up_state", 32'(state), 32'(S_UP));
        check("up_ctrl",  32'(control), 32'd2);
        check("up_cmp0",  compare, 32'd0);
        check("up_max",   max_count, 32'd99);
        check("up_pres",  prescalor, 32'd3);
        check("up_busy",  32'(busy), 32'd1);
        for (int k = 1; k <= 5; k++) begin
            edges(3);
            check("up_nostep", compare, 32'(10 * (k - 1)));
            edges(1);
            check("up_step", compare, 32'(10 * k));
        end
        check("up_st50", 32'(state), 32'(S_UP));
        edges(1);
        check("up_hold",  32'(state), 32'(S_HOLD));
        check("up_attgt", 32'(at_target), 32'd1);

        // Non-multiple target lands exactly on 55.
        target_duty = 16'd55;
        edges(1);
        check("nm_state", 32'(state), 32'(S_UP));
        check("nm_cmp50", compare, 32'd50);
        edges(4);
        check("nm_cmp55", compare, 32'd55);
        edges(1);
        check("nm_hold", 32'(state), 32'(S_HOLD));

        // Oversized target clamps at period+1; period change while busy is ignored.
        target_duty = 16'd500;
        period_cfg  = 16'd10;
        edges(1);
        check("cl_state", 32'(state), 32'(S_UP));
        for (int k = 1; k <= 5; k++) begin
            edges(4);
            check("cl_step", compare, (k == 5) ? 32'd100 : 32'(55 + 10 * k));
        end
        edges(1);
        check("cl_hold", 32'(state), 32'(S_HOLD));
        check("cl_cmp",  compare, 32'd100);
        check("cl_max",  max_count, 32'd99);
        edges(8);
        check("cl_stay", compare, 32'd100);

        // Back down to 50 with step 20: 80, 60, 50.
        step_size   = 16'd20;
        target_duty = 16'd50;
        edges(1);
        check("dn_state", 32'(state), 32'(S_DOWN));
        check("dn_cmp",   compare, 32'd100);
        edges(4); check("dn_80", compare, 32'd80);
        edges(4); check("dn_60", compare, 32'd60);
        edges(4); check("dn_50", compare, 32'd50);
        edges(1); check("dn_hold", 32'(state), 32'(S_HOLD));

        // Soft stop: 30, 10, 0, then OFF.
        cmd_run = 1'b0;
        edges(1);
        check("ss_state", 32'(state), 32'(S_DOWN));
        check("ss_cmp",   compare, 32'd50);
        check("ss_ctrl",  32'(control), 32'd2);
        edges(4); check("ss_30", compare, 32'd30);
        edges(4); check("ss_10", compare, 32'd10);
        edges(4); check("ss_0",  compare, 32'd0);
        check("ss_busy0", 32'(busy), 32'd1);
        edges(1);
        check_idle("ss_off");

        // Retarget mid-ramp: heading to 80, at 30 ask for 20.
        period_cfg  = 16'd99;
        step_size   = 16'd10;
        target_duty = 16'd80;
        cmd_run     = 1'b1;
        edges(1);
        check("rt_state", 32'(state), 32'(S_UP));
        edges(12);
        check("rt_30", compare, 32'd30);
        target_duty = 16'd20;
        edges(1);
        check("rt_down",  32'(state), 32'(S_DOWN));
        check("rt_cmp30", compare, 32'd30);
        edges(4);
        check("rt_20", compare, 32'd20);
        edges(1);
        check("rt_hold", 32'(state), 32'(S_HOLD));

        // Emergency stop at 40 with cmd_run held.
        target_duty = 16'd40;
        edges(9);
        check("es_40", compare, 32'd40);
        estop = 1'b1;
        edges(1);
        check_idle("es_cut");
        edges(5);
        check_idle("es_held");
        estop = 1'b0;
        edges(1);
        check("es_restart", 32'(state), 32'(S_UP));
        check("es_cmp0",    compare, 32'd0);
        edges(4);
        check("es_10", compare, 32'd10);

        // Asynchronous reset mid-ramp, checked before the next rising edge.
        reset = 1'b0;
        #1;
        check_idle("ar");
        check("ar_max",  max_count, 32'd0);
        check("ar_pres", prescalor, 32'd0);

        // step_size 0 behaves as 1, interval 0 steps every edge.
        step_size     = 16'd0;
        step_interval = 16'd0;
        target_duty   = 16'd3;
        edges(1);
        reset = 1'b1;
        edges(1);
        check("z_state", 32'(state), 32'(S_UP));
        check("z_cmp0",  compare, 32'd0);
        for (int k = 1; k <= 3; k++) begin
            edges(1);
            check("z_step", compare, 32'(k));
        end
        edges(1);
        check("z_hold", 32'(state), 32'(S_HOLD));
        check("z_cmp",  compare, 32'd3);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
